// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;

    modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemData);
    modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemData);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: single-outstanding fetch, stall hold, redirect squash.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_PCWrite,
    input  logic        i_IFIDWrite,
    input  logic        i_IFIDFlush,
    input  logic [31:0] i_BranchTarget,
    fetch_stage_if.master imem,
    output logic [31:0] o_IFIDInstruction,
    output logic [31:0] o_IFIDPC,
    output logic        o_IFIDValid,
    output logic [31:0] o_FlushCount,
    output logic [31:0] o_StallCount
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HELD = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic [31:0] r_redirect;
    logic [31:0] r_ifidInstr;
    logic [31:0] r_ifidPc;
    logic        r_ifidValid;

    state_t      w_stateNext;
    logic [31:0] w_pcNext;
    logic [31:0] w_holdNext;
    logic [31:0] w_redirectNext;
    logic [31:0] w_ifidInstrNext;
    logic [31:0] w_ifidPcNext;
    logic        w_ifidValidNext;

    logic [31:0] w_target;
    logic [31:0] w_pcPlus4;
    logic        w_advance;
    logic [1:0]  w_unusedTgtLsb;

    assign w_target       = {i_BranchTarget[31:2], 2'b00};
    assign w_unusedTgtLsb = i_BranchTarget[1:0];
    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_advance      = i_IFIDWrite & i_PCWrite;

    // In DROP the PC still holds the squashed address, so the request stays stable until its ack.
    assign imem.ImemReq  = ~rst & (r_state != ST_HELD);
    assign imem.ImemAddr = r_pc;

    assign o_IFIDInstruction = r_ifidInstr;
    assign o_IFIDPC          = r_ifidPc;
    assign o_IFIDValid       = r_ifidValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_hold      <= 32'h0;
            r_redirect  <= 32'h0;
            r_ifidInstr <= NOP_INSTR;
            r_ifidPc    <= 32'h0;
            r_ifidValid <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_hold      <= w_holdNext;
            r_redirect  <= w_redirectNext;
            r_ifidInstr <= w_ifidInstrNext;
            r_ifidPc    <= w_ifidPcNext;
            r_ifidValid <= w_ifidValidNext;
        end
    end

    // A flush always wins, even over a stall; bubbles keep the previous IF/ID PC.
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_holdNext      = r_hold;
        w_redirectNext  = r_redirect;
        w_ifidInstrNext = r_ifidInstr;
        w_ifidPcNext    = r_ifidPc;
        w_ifidValidNext = r_ifidValid;

        case (r_state)
            ST_REQ: begin
                if (i_IFIDFlush) begin
                    w_ifidInstrNext = NOP_INSTR;
                    w_ifidValidNext = 1'b0;
                    if (imem.ImemAck) begin
                        w_pcNext = w_target;
                    end else begin
                        w_redirectNext = w_target;
                        w_stateNext    = ST_DROP;
                    end
                end else if (imem.ImemAck) begin
                    if (w_advance) begin
                        w_ifidInstrNext = imem.ImemData;
                        w_ifidPcNext    = r_pc;
                        w_ifidValidNext = 1'b1;
                        w_pcNext        = w_pcPlus4;
                    end else begin
                        w_holdNext  = imem.ImemData;
                        w_stateNext = ST_HELD;
                    end
                end else if (i_IFIDWrite) begin
                    w_ifidInstrNext = NOP_INSTR;
                    w_ifidValidNext = 1'b0;
                end
            end

            ST_HELD: begin
                if (i_IFIDFlush) begin
                    w_ifidInstrNext = NOP_INSTR;
                    w_ifidValidNext = 1'b0;
                    w_pcNext        = w_target;
                    w_stateNext     = ST_REQ;
                end else if (w_advance) begin
                    w_ifidInstrNext = r_hold;
                    w_ifidPcNext    = r_pc;
                    w_ifidValidNext = 1'b1;
                    w_pcNext        = w_pcPlus4;
                    w_stateNext     = ST_REQ;
                end
            end

            ST_DROP: begin
                if (i_IFIDFlush || i_IFIDWrite) begin
                    w_ifidInstrNext = NOP_INSTR;
                    w_ifidValidNext = 1'b0;
                end
                if (i_IFIDFlush) begin
                    if (imem.ImemAck) begin
                        w_pcNext    = w_target;
                        w_stateNext = ST_REQ;
                    end else begin
                        w_redirectNext = w_target;
                    end
                end else if (imem.ImemAck) begin
                    w_pcNext    = r_redirect;
                    w_stateNext = ST_REQ;
                end
            end

            default: begin
                w_stateNext = ST_REQ;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_flushCount;
    logic [31:0] r_stallCount;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushCount <= 32'h0;
            r_stallCount <= 32'h0;
        end else begin
            if (i_IFIDFlush && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
            if (!i_IFIDWrite && !i_IFIDFlush && (r_stallCount != 32'hFFFF_FFFF)) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end

    assign o_FlushCount = r_flushCount;
    assign o_StallCount = r_stallCount;
`else
    assign o_FlushCount = 32'h0;
    assign o_StallCount = 32'h0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core, sitting directly upstream of hazard detection and the decode stage. It owns the PC, issues single-outstanding requests to instruction memory over a req/ack handshake, and loads the IF/ID register. It obeys the stall controls `PCWrite`/`IFIDWrite` and the branch-redirect control `IFIDFlush`/`BranchTarget` coming back from ID. Memory wait states and stalls never lose or duplicate an instruction; a redirect never lets a wrong-path instruction reach ID.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) loaded on flush or memory wait.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PCWrite`  in  1  1 = PC may advance. Driven equal to `IFIDWrite` by hazard detection.
- `IFIDWrite`  in  1  1 = IF/ID may load.
- `IFIDFlush`  in  1  redirect to `BranchTarget`; squash the IF/ID contents.
- `BranchTarget`  in  32  redirect address; bits [1:0] are ignored (forced to 0).
- `ImemReq`  out  1  request valid.
- `ImemAddr`  out  32  request address, word aligned.
- `ImemAck`  in  1  response valid this cycle. May be high in the same cycle as `ImemReq`.
- `ImemData`  in  32  instruction; sampled only when `ImemAck`=1.
- `IFIDInstruction`  out  32  instruction presented to ID.
- `IFIDPC`  out  32  PC of `IFIDInstruction`.
- `IFIDValid`  out  1  1 = real instruction; 0 = bubble.
- `FlushCount`  out  32  performance counter; see Configuration.
- `StallCount`  out  32  performance counter; see Configuration.

## Operation
- **FSM states:**
  - REQ: request outstanding.
  - HELD: response captured while ID was stalled.
  - DROP: wrong-path response still owed by memory.
- **Request outputs:**
  - `ImemReq`=1 in REQ and DROP; 0 in HELD and while `rst`=1.
  - `ImemAddr`=PC in REQ. In DROP it holds the address of the squashed request.
  - Address and request stay stable until `ImemAck`.
- **Redirect priority:** `IFIDFlush` has priority over every other event, including `IFIDWrite`=0.
- **REQ, flush cycle:**
  - IF/ID <= {`NOP_INSTR`, PC unchanged, valid 0}.
  - If `ImemAck`=1: response discarded, PC <= target, stay in REQ.
  - Otherwise: target latched into a redirect register, go to DROP.
- **REQ, no flush:**
  - `ImemAck`=1 with `IFIDWrite`=`PCWrite`=1: IF/ID <= {`ImemData`, PC, 1}; PC <= PC+4.
  - `ImemAck`=1 with stall: `ImemData` goes to the hold register, go to HELD. IF/ID and PC unchanged.
  - `ImemAck`=0 with `IFIDWrite`=1: IF/ID <= bubble {`NOP_INSTR`, valid 0}.
  - `ImemAck`=0 with stall: IF/ID unchanged.
- **HELD:**
  - Flush: hold register dropped, IF/ID <= bubble, PC <= target, go to REQ.
  - `IFIDWrite`=1: IF/ID <= {hold, PC, 1}; PC <= PC+4; go to REQ.
  - Otherwise: remain in HELD.
- **DROP:**
  - On `ImemAck`: data discarded, PC <= redirect register, go to REQ.
  - A new flush in DROP overwrites the redirect register.
  - IF/ID loads a bubble whenever `IFIDWrite`=1 or a flush occurs.
- **PC arithmetic:** PC+4 is a 32-bit add; 32'hFFFF_FFFC wraps to 0.
- **Reset:** mid-transaction reset abandons any in-flight request. A late `ImemAck` after reset is treated as the response to the first new request; the memory must not return stale acks.

## Timing
- **Reset values:**
  - State REQ, PC=`RESET_PC`.
  - `IFIDInstruction`=`NOP_INSTR`, `IFIDPC`=0, `IFIDValid`=0.
  - Counters 0; hold and redirect registers 0.
- **Start-up:** first cycle after `rst` falls: `ImemReq`=1, `ImemAddr`=`RESET_PC`.
- **Latency:** ack cycle to IF/ID valid is one edge. A zero-wait memory sustains one instruction per cycle.
- **Redirect:** flush edge to `ImemAddr`=target is next cycle if acked (or in HELD). Otherwise it is the cycle after the pending ack.
- **Hazard feedback:** `PCWrite` ≠ `IFIDWrite` is illegal. The bench asserts they are equal.

## Configuration
- **Macro:** `FETCH_PERF_CNT_EN`.
- **With the macro defined:**
  - `FlushCount` increments every cycle `IFIDFlush`=1.
  - `StallCount` increments every cycle `IFIDWrite`=0 with `IFIDFlush`=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- **Without it:** both ports are driven constant 0 and no counter flops exist. Fetch behaviour is identical.

## Test plan
- **Zero-wait sequential fetch:** `ImemAck` tied to `ImemReq`, data = address; reset released. Expected: IF/ID shows PCs 0,4,8,12 on consecutive edges, `IFIDValid`=1, data = PC.
- **Stall while instruction returns:** ack at PC 8 with `IFIDWrite`=`PCWrite`=0 for 3 cycles. Expected: state HELD, `ImemReq`=0, IF/ID holds PC 4. After release, IF/ID = PC 8 with the correct data, then `ImemAddr`=12.
- **Flush with memory wait:** 2-wait-state memory; flush with `BranchTarget`=32'h100 while the request to 12 is outstanding. Expected: IF/ID bubble (`NOP_INSTR`, valid 0). The response for 12 is never presented. Next request address is 32'h100.
- **Flush overrides stall:** flush and `IFIDWrite`=0 in the same cycle, target 32'h203. Expected: IF/ID bubble; next fetch 32'h200.
- **Reset mid-operation:** `rst` asserted during DROP. Expected: all outputs at reset values immediately (asynchronous); fetch restarts at `RESET_PC`.
- **Counters (macro defined):** 5 stall cycles and 2 flush cycles. Expected: `StallCount`=5, `FlushCount`=2. Without the macro, both read 0.
